// File: rtl/dmux_seq_pkg.sv
// Shared types and defaults for the demux frame sequencer.
package dmux_seq_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  localparam int unsigned SEL_W_DEF  = 3;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned HOLD_DEF   = 2;
  localparam int unsigned HOLD_CNT_W = 8;

endpackage

// File: rtl/dmux_frame_sequencer_slot_timer.sv
// Hold/slot counter pair: each slot lasts HOLD cycles, slots run 0..2**SEL_W-1.
module slot_timer
  import dmux_seq_pkg::*;
#(
  parameter int unsigned SEL_W = SEL_W_DEF,
  parameter int unsigned HOLD  = HOLD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  output logic [SEL_W-1:0] slot,
  output logic [SEL_W-1:0] slot_nxt,
  output logic             last_cycle_of_slot,
  output logic             last_cycle_of_frame
);

  logic [SEL_W-1:0]      slot_q, slot_d;
  logic [HOLD_CNT_W-1:0] hold_q, hold_d;

  assign last_cycle_of_slot  = (hold_q == HOLD_CNT_W'(HOLD - 1));
  assign last_cycle_of_frame = last_cycle_of_slot && (slot_q == '1);

  always_comb begin
    slot_d = slot_q;
    hold_d = hold_q;
    if (clear || start) begin
      slot_d = '0;
      hold_d = '0;
    end else if (last_cycle_of_slot) begin
      hold_d = '0;
      slot_d = slot_q + SEL_W'(1);
    end else begin
      hold_d = hold_q + HOLD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      hold_q <= '0;
    end else begin
      slot_q <= slot_d;
      hold_q <= hold_d;
    end
  end

  assign slot     = slot_q;
  assign slot_nxt = slot_d;

endmodule

// File: rtl/dmux_frame_sequencer.sv
// Back-pressured feeder that walks a captured word bit-by-bit onto a 1-to-N demux.
module dmux_frame_sequencer
  import dmux_seq_pkg::*;
#(
  parameter int unsigned SEL_W  = SEL_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned HOLD   = HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic [SEL_W-1:0]  sel,
  output logic              dout,
  output logic              slot_valid,
  output logic              frame_done,
  output logic              busy
);

  if (DATA_W != (1 << SEL_W)) begin : g_width_check
    $error("DATA_W must equal 2**SEL_W");
  end
  if (HOLD < 1 || HOLD > 255) begin : g_hold_check
    $error("HOLD must be in 1..255");
  end

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              dout_q, dout_d;
  logic              slot_valid_q, slot_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              frame_end;
  logic              timer_clear;
  logic [SEL_W-1:0]  slot, slot_nxt;
  logic              last_slot, last_frame;

  slot_timer #(
    .SEL_W (SEL_W),
    .HOLD  (HOLD)
  ) u_slot_timer (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (accept),
    .clear               (timer_clear),
    .slot                (slot),
    .slot_nxt            (slot_nxt),
    .last_cycle_of_slot  (last_slot),
    .last_cycle_of_frame (last_frame)
  );

  assign frame_end = (state_q == SEND) && last_frame;
  assign in_ready  = !flush && ((state_q == IDLE) || frame_end);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    frame_done_d = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      frame_done_d = frame_end;
      if (accept) begin
        state_d  = SEND;
        shadow_d = in_data;
      end else if (frame_end) begin
        state_d = IDLE;
      end
    end

    timer_clear  = (state_d == IDLE);
    slot_valid_d = (state_d == SEND);
    busy_d       = (state_d == SEND);

    // dout only moves on slot boundaries; the shadow word is frozen within a frame.
    if (state_d == IDLE) begin
      dout_d = 1'b0;
    end else if (accept || last_slot) begin
      dout_d = shadow_d[slot_nxt];
    end else begin
      dout_d = dout_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      dout_q       <= 1'b0;
      slot_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      dout_q       <= dout_d;
      slot_valid_q <= slot_valid_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign sel        = slot;
  assign dout       = dout_q;
  assign slot_valid = slot_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = busy_q;

endmodule

// File: doc/dmux_frame_sequencer.md
Name: dmux_frame_sequencer

Overview:
Upstream feeder for the 1-to-8 demultiplexer. It accepts a parallel 8-bit word over a valid/ready handshake and walks the demux select through channels 0..7. On each channel it drives the matching data bit on the demux data input and holds it for a programmable number of cycles. This replaces hand-driven sel/in sweeps with a clocked, back-pressured source.

Parameters:
SEL_W, 3, select width; channel count is 2**SEL_W.
DATA_W, 8, word width; must equal 2**SEL_W (elaboration-time check).
HOLD, 2, clock cycles each slot is held; legal range 1..255.

Ports:
clk  in  1  single system clock, rising edge.
rst_n  in  1  asynchronous active-low reset; deassertion is synchronous to clk externally.
in_valid  in  1  upstream word valid.
in_data  in  DATA_W  word to distribute; bit k goes to channel k.
in_ready  out  1  block can accept a word this cycle.
flush  in  1  synchronous abort of the current frame.
sel  out  SEL_W  demux select.
dout  out  1  demux data input (in_data[sel] of the captured word).
slot_valid  out  1  sel/dout carry live frame data.
frame_done  out  1  one-cycle pulse after the final slot of a frame.
busy  out  1  a frame is in progress.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, sel=0, dout=0, slot_valid=0, frame_done=0, busy=0, shadow word=0, hold counter=0.
- All outputs are registered. in_ready is combinational from state and counters only, never from in_valid.
- States:
  - IDLE: in_ready=1, slot_valid=0, sel=0, dout=0.
  - SEND: slot_valid=1, busy=1.
- Accept happens when in_valid && in_ready at edge N. At that edge in_data is captured into the shadow register, slot=0, hold=0, state becomes SEND. The first slot is visible in the cycle after edge N.
- SEND operation:
  - sel=slot, dout=shadow[slot].
  - hold increments each cycle. When hold==HOLD-1, hold returns to 0 and slot increments.
  - Each slot is visible for exactly HOLD cycles. A frame occupies 8*HOLD consecutive cycles.
- Last cycle of a frame (slot==2**SEL_W-1 and hold==HOLD-1):
  - in_ready=1.
  - If a word is accepted at that edge, the next frame starts immediately: slot returns to 0 and there are no idle gaps.
  - If no word is accepted, state becomes IDLE.
  - In either case frame_done=1 for exactly the next cycle.
- in_ready=0 in SEND except in that last cycle. in_valid while not ready is ignored, and in_data may change freely.
- Shadow word is stable for the whole frame; in_data changes mid-frame have no effect.
- flush=1:
  - In SEND: next state IDLE, outputs go to idle values, frame_done stays 0, no word is accepted that cycle (in_ready forced 0).
  - In IDLE: flush=1 blocks acceptance that cycle.
  - flush has priority over accept and frame completion.
- HOLD=1: slot advances every cycle, frame=8 cycles, and back-to-back frames are gapless.
- Reset mid-frame: frame is abandoned, no frame_done, IDLE on the first edge after rst_n returns high.
- Slot counter is SEL_W bits and wraps naturally 7->0 only on frame restart. Hold counter is 8 bits; its compare is against HOLD-1.

Decomposition:
- Package dmux_seq_pkg holds:
  - state enum {IDLE, SEND}
  - SEL_W_DEF=3, DATA_W_DEF=8, HOLD_DEF=2
  - HOLD_CNT_W=8
- One sub-module, slot_timer, contains the hold counter plus slot counter. Inputs: start/clear. Outputs: slot, last_cycle_of_slot, last_cycle_of_frame.
- The FSM, handshake and output registers stay in dmux_frame_sequencer.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, release → in_ready=1, sel=0, dout=0, slot_valid=0, busy=0, frame_done=0.
- Single frame, HOLD=2, in_data=8'hA5:
  - sel steps 0..7, two cycles each.
  - dout = 1,0,1,0,0,1,0,1 per sel.
  - frame_done pulses once at cycle 17 after acceptance.
  - Block then returns to IDLE.
- Back-to-back, HOLD=1, words 8'hFF then 8'h00 with in_valid held high:
  - dout=1 for 8 cycles then 0 for 8 cycles, no gap.
  - frame_done at cycles 9 and 17.
  - in_ready is high only on cycles 8 and 16.
- Backpressure: present 8'h3C mid-frame and change in_data to 8'hC3 while in_ready=0 → current frame unaffected; 8'hC3 is accepted at the frame's last cycle and then sent.
- Flush: assert flush at slot 3 of frame 8'h81 → next cycle slot_valid=0, sel=0, dout=0, no frame_done; a new word is accepted the following cycle.
- Async reset mid-frame: drop rst_n at slot 5 between clock edges → outputs clear immediately without a clock edge, no frame_done.
